// File: rtl/bw_search_ctrl.sv
// Sequencer for the bandwidth left-edge search engine: arms on a frame, freezes the
// accumulator bank, starts the engine, waits for its result (with timeout) and holds it.
module bw_search_ctrl #(
    parameter int ACCUM_WIDTH    = 18,
    parameter int FREQ_BIN_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic                      continuous_i,
    input  logic                      trigger_i,
    input  logic                      frame_done_i,
    output logic                      freeze_o,
    output logic                      eng_start_o,
    input  logic                      eng_busy_i,
    input  logic                      eng_valid_i,
    input  logic [FREQ_BIN_WIDTH-1:0] eng_f1_i,
    input  logic [FREQ_BIN_WIDTH-1:0] eng_f2_i,
    input  logic [ACCUM_WIDTH-1:0]    eng_L1_i,
    input  logic [ACCUM_WIDTH-1:0]    eng_L2_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [FREQ_BIN_WIDTH-1:0] res_f1_o,
    output logic [FREQ_BIN_WIDTH-1:0] res_f2_o,
    output logic [ACCUM_WIDTH-1:0]    res_L1_o,
    output logic [ACCUM_WIDTH-1:0]    res_L2_o,
    output logic                      res_timeout_o,
    output logic                      overrun_o,
    input  logic                      clear_i,
    output logic [CNT_WIDTH-1:0]      meas_count_o,
    output logic [7:0]                drop_count_o
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_WAIT,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMO_W-1:0] r_tmo;
    logic             w_capture;
    logic             w_timeout;
    logic             w_drop;

    assign w_capture = (r_state == S_WAIT) && eng_valid_i;
    assign w_timeout = (r_state == S_WAIT) && !eng_valid_i && (r_tmo == '0);
    assign w_drop    = frame_done_i && enable_i && (r_state != S_ARM);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (enable_i && (continuous_i || trigger_i)) w_state_nxt = S_ARM;
            S_ARM: begin
                if (!enable_i)         w_state_nxt = S_IDLE;
                else if (frame_done_i) w_state_nxt = S_START;
            end
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_capture)      w_state_nxt = S_HOLD;
                else if (w_timeout) w_state_nxt = S_DRAIN;
            end
            // A late engine valid here is dropped; only a quiet engine releases the bank.
            S_DRAIN: if (!eng_busy_i && !eng_valid_i) w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (res_ready_i)
                    w_state_nxt = (enable_i && continuous_i) ? S_ARM : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        freeze_o    = 1'b0;
        eng_start_o = 1'b0;
        res_valid_o = 1'b0;
        case (r_state)
            S_START: begin
                freeze_o    = 1'b1;
                eng_start_o = 1'b1;
            end
            S_WAIT:  freeze_o    = 1'b1;
            S_DRAIN: freeze_o    = 1'b1;
            S_HOLD:  res_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tmo <= '0;
        end else if (r_state == S_START) begin
            r_tmo <= TMO_LOAD;
        end else if (r_state == S_WAIT && r_tmo != '0) begin
            r_tmo <= r_tmo - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_f1_o      <= '0;
            res_f2_o      <= '0;
            res_L1_o      <= '0;
            res_L2_o      <= '0;
            res_timeout_o <= 1'b0;
        end else if (w_capture) begin
            res_f1_o      <= eng_f1_i;
            res_f2_o      <= eng_f2_i;
            res_L1_o      <= eng_L1_i;
            res_L2_o      <= eng_L2_i;
            res_timeout_o <= 1'b0;
        end else if (w_timeout) begin
            res_f1_o      <= '0;
            res_f2_o      <= '0;
            res_L1_o      <= '0;
            res_L2_o      <= '0;
            res_timeout_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_o    <= 1'b0;
            meas_count_o <= '0;
            drop_count_o <= '0;
        end else if (clear_i) begin
            overrun_o    <= 1'b0;
            meas_count_o <= '0;
            drop_count_o <= '0;
        end else begin
            if (w_capture) meas_count_o <= meas_count_o + 1'b1;
            if (w_drop) begin
                overrun_o <= 1'b1;
                if (drop_count_o != 8'hFF) drop_count_o <= drop_count_o + 1'b1;
            end
        end
    end

endmodule
